// File: rtl/gray_bin_serial_ctrl.sv
// Sequencer for the serial Gray-to-binary datapath (PISO -> serial gray/bin FSM -> SIPO).
// Define GBSC_PERF_EN to add the frame_cnt / stall_cnt performance counters.
module gray_bin_serial_ctrl #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned CAP_LAT   = WIDTH + 2,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dp_data,
  output logic             dp_shift,
  input  logic [WIDTH-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef GBSC_PERF_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned PhW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  localparam logic [PhW-1:0]  PhLast  = PhW'(WIDTH - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(OUT_DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OUT_DEPTH);

  typedef logic [PhW-1:0] ph_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Phase counter, aligned with the datapath frame FSM (both reset by rst_n).
  ph_t ph_q, ph_d;

  // Credits: FIFO occupancy plus frames in flight.
  logic [CntW-1:0] cnt_q, cnt_d;

  // Launch pipe; its last tap marks the SIPO capture cycle.
  logic [CAP_LAT-1:0] pipe_q, pipe_d;

  // Output FIFO.
  logic [WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [WIDTH-1:0] mem_d [OUT_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  occ_q, occ_d;

  logic launch;
  logic capture;
  logic pop;

  // in_ready depends only on registered state, never on in_valid.
  always_comb begin
    in_ready  = (ph_q == PhLast) && (cnt_q < CntFull);
    launch    = in_valid && in_ready;
    dp_shift  = ~launch;
    dp_data   = in_data;
    capture   = pipe_q[CAP_LAT-1];
    out_valid = (occ_q != '0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    busy      = (cnt_q != '0);
  end

  always_comb begin
    ph_d   = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
    pipe_d = {pipe_q[CAP_LAT-2:0], launch};

    cnt_d = cnt_q;
    if (launch && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!launch && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (capture) begin
      mem_d[wr_ptr_q] = dp_result;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Simultaneous capture and pop leave the occupancy unchanged.
    if (capture && !pop) begin
      occ_d = occ_q + CntW'(1);
    end else if (!capture && pop) begin
      occ_d = occ_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= '0;
      cnt_q    <= '0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(capture && !pop && (occ_q == CntFull)))
        else $fatal(1, "gray_bin_serial_ctrl: output FIFO overflow");
    end
  end
`endif

`ifdef GBSC_PERF_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    frame_cnt_d = capture ? frame_cnt_q + 16'd1 : frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (in_valid && (ph_q == PhLast) && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gray_bin_serial_ctrl.sv
// Self-checking bench for gray_bin_serial_ctrl with a behavioural PISO/FSM/SIPO datapath.
module tb_gray_bin_serial_ctrl;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, dp_shift, out_valid, busy;
  logic [W-1:0] dp_data, dp_result, out_data;
`ifdef GBSC_PERF_EN
  logic [15:0]  frame_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  gray_bin_serial_ctrl #(.WIDTH(W), .CAP_LAT(W + 2), .OUT_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_data   (dp_data),
    .dp_shift  (dp_shift),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef GBSC_PERF_EN
    ,
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Datapath: PISO (MSB first) -> frame-aligned Gray-to-binary FSM -> SIPO.
  logic [W-1:0] piso, sipo;
  logic         bout;
  int           fph;
  int           cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso <= '0;
      sipo <= '0;
      bout <= 1'b0;
      fph  <= 0;
      cyc  <= 0;
    end else begin
      piso <= dp_shift ? (piso << 1) : dp_data;
      bout <= (fph == 0) ? piso[W-1] : (bout ^ piso[W-1]);
      sipo <= {sipo[W-2:0], bout};
      fph  <= (fph == W - 1) ? 0 : fph + 1;
      cyc  <= cyc + 1;
    end
  end
  assign dp_result = sipo;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } vec_t;
  vec_t vecs[6];

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           acc_cyc[$];
  int           out_cyc[$];
  logic [W-1:0] cur_exp = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        chk("load_dp_shift", dp_shift, 0);
        chk("load_dp_data", dp_data, in_data);
        exp_q.push_back(cur_exp);
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] e);
    bit hit = 1'b0;
    cur_exp  = e;
    in_data  = g;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send_accept", hit, 1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", n < 200, 1);
  endtask

  // mode 0: out_ready low, 1: out_ready high, 2: random out_ready
  task automatic stream(input int ncyc, input int mode);
    logic [W-1:0] g;
    bit acc;
    if (!in_valid) begin
      g        = W'($urandom);
      cur_exp  = g2b(g);
      in_data  = g;
      in_valid = 1'b1;
    end
    for (int i = 0; i < ncyc; i++) begin
      out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        g       = W'($urandom);
        cur_exp = g2b(g);
        in_data = g;
      end
    end
  endtask

  initial begin
    int r;
    int exp_c;

    vecs[0] = '{gray: 5'b11010, bin: 5'b10011};
    vecs[1] = '{gray: 5'b00000, bin: 5'b00000};
    vecs[2] = '{gray: 5'b10000, bin: 5'b11111};
    vecs[3] = '{gray: 5'b11010, bin: 5'b10011};
    vecs[4] = '{gray: 5'b11111, bin: 5'b10101};
    vecs[5] = '{gray: 5'b01010, bin: 5'b01100};

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dp_shift", dp_shift, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Test 1: first accept in cycle 4, result 8 cycles later
    out_ready = 1'b1;
    clear_sb();
    send(vecs[0].gray, vecs[0].bin);
    drain();
    chk("t1_outputs", out_cyc.size(), 1);
    if (acc_cyc.size() > 0 && out_cyc.size() > 0) begin
      chk("t1_first_accept", acc_cyc[0], 4);
      chk("t1_latency", out_cyc[0] - acc_cyc[0], 8);
    end

    // Test 2: table vectors back-to-back
    clear_sb();
    for (int i = 1; i < 6; i++) send(vecs[i].gray, vecs[i].bin);
    drain();
    chk("t2_accepts", acc_cyc.size(), 5);
    chk("t2_outputs", out_cyc.size(), 5);
    if (acc_cyc.size() == 5 && out_cyc.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        chk("t2_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
        chk("t2_output_spacing", out_cyc[i] - out_cyc[i-1], 5);
      end
      chk("t2_latency", out_cyc[0] - acc_cyc[0], 8);
    end

    // Test 3: consumer stalled, credits limit launches to two
    clear_sb();
    stream(40, 0);
    chk("t3_accepts_stalled", acc_cyc.size(), 2);
    chk("t3_in_ready_stalled", in_ready, 0);
    chk("t3_out_valid_stalled", out_valid, 1);
    chk("t3_busy_stalled", busy, 1);
    r = cyc;
    stream(30, 1);
    in_valid = 1'b0;
    drain();
    chk("t3_resumed", acc_cyc.size() > 2, 1);
    if (acc_cyc.size() > 2) begin
      exp_c = r + 1;
      while (exp_c % 5 != 4) exp_c++;
      chk("t3_resume_cycle", acc_cyc[2], exp_c);
    end

    // Test 4: in_valid raised at ph=1 is held until ph=4
    clear_sb();
    for (int i = 0; i < 10 && fph != 1; i++) step();
    chk("t4_ph1", fph, 1);
    cur_exp  = vecs[5].bin;
    in_data  = vecs[5].gray;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_dp_shift", dp_shift, 1);
      chk("t4_hold_in_ready", in_ready, 0);
      step();
    end
    @(negedge clk);
    chk("t4_load_ph", fph, 4);
    chk("t4_load_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain();
    chk("t4_outputs", out_cyc.size(), 1);

    // Test 5: reset 3 cycles after an accept
    clear_sb();
    send(vecs[4].gray, vecs[4].bin);
    step();
    step();
    chk("t5_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    clear_sb();
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_post_in_ready", in_ready, 0);
    chk("t5_post_out_valid", out_valid, 0);
    send(vecs[2].gray, vecs[2].bin);
    drain();
    chk("t5_outputs", out_cyc.size(), 1);
    if (acc_cyc.size() > 0) chk("t5_first_accept", acc_cyc[0], 4);

    // Test 6: random words with random back-pressure
    clear_sb();
    stream(400, 2);
    in_valid = 1'b0;
    drain();
    chk("t6_accepts", acc_cyc.size() >= 20, 1);
    chk("t6_no_loss", out_cyc.size(), acc_cyc.size());
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
